oam_dma: RTL

OAM DMA engine: the bus-initiating counterpart to the PPU's memory-mapped sprite attribute table (0xFE00–0xFE9F). It decodes the 0xFF46 register on the CPU side, arbitrates the system load/store bus, and copies 160 bytes from a source page into OAM by issuing reads and writes to the bus responders. It sits between the CPU and the system bus mux, on the `clockgb` domain.

---
 rtl/oam_dma.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/oam_dma.sv
// OAM DMA engine.
// Decodes the source-page register on the CPU side and arbitrates the system bus. On a trigger
// it copies OAM_BYTES bytes from {src_page, idx} to OAM_BASE + idx. Each byte takes three
// cycles: READ, WAIT (data capture) and WRITE.
//
// Ports:
//   clockgb      system clock
//   reset        asynchronous active-high reset
//   cpu_*        CPU-side request (address, wdata, load, store) and returned rdata
//   bus_*        system bus request (address, wdata, load, store) and OR-combined rdata
//   dma_active   high while a transfer owns the bus
//
// Build option: OAM_DMA_RESTART_EN. When defined, a register store during a transfer restarts
// the copy from the new page. When undefined, the store only updates the register.
module oam_dma #(
  parameter logic [15:0] OAM_BASE  = 16'hfe00,
  parameter int unsigned OAM_BYTES = 160,
  parameter logic [15:0] REG_ADDR  = 16'hff46
) (
  input  logic        clockgb,
  input  logic        reset,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_load,
  input  logic        cpu_store,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] bus_address,
  output logic [7:0]  bus_wdata,
  output logic        bus_load,
  output logic        bus_store,
  input  logic [7:0]  bus_rdata,
  output logic        dma_active
);

  localparam logic [7:0] LastIdx = 8'(OAM_BYTES - 1);

  typedef enum logic [2:0] {StIdle, StStart, StRead, StWait, StWrite} state_e;

  state_e     r_state, w_state;
  logic [7:0] r_page, w_page;
  logic [7:0] r_src, w_src;
  logic [7:0] r_idx, w_idx;
  logic [7:0] r_data, w_data;
  logic       r_rd_page;   // previous cycle was a CPU load of the register
  logic       r_rd_owned;  // previous cycle belonged to the DMA

  logic       w_reg_store;
  logic       w_reg_load;
  logic [7:0] w_fold;

  assign w_reg_store = cpu_store && (cpu_address == REG_ADDR);
  assign w_reg_load  = cpu_load && (cpu_address == REG_ADDR);
  // Echo RAM pages 0xE0-0xFF alias 0xC0-0xDF.
  assign w_fold      = (cpu_wdata > 8'hdf) ? (cpu_wdata - 8'h20) : cpu_wdata;

  always_ff @(posedge clockgb or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_page     <= 8'h00;
      r_src      <= 8'h00;
      r_idx      <= 8'h00;
      r_data     <= 8'h00;
      r_rd_page  <= 1'b0;
      r_rd_owned <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_page     <= w_page;
      r_src      <= w_src;
      r_idx      <= w_idx;
      r_data     <= w_data;
      r_rd_page  <= w_reg_load;
      r_rd_owned <= (r_state != StIdle);
    end
  end

  always_comb begin
    w_state = r_state;
    w_page  = w_reg_store ? cpu_wdata : r_page;
    w_src   = r_src;
    w_idx   = r_idx;
    w_data  = r_data;
    unique case (r_state)
      StIdle: begin
        if (w_reg_store) begin
          w_state = StStart;
          w_src   = w_fold;
          w_idx   = 8'h00;
        end
      end
      StStart: w_state = StRead;
      StRead:  w_state = StWait;
      StWait: begin
        w_data  = bus_rdata;
        w_state = StWrite;
      end
      StWrite: begin
        if (r_idx != LastIdx) begin
          w_idx   = r_idx + 8'h01;
          w_state = StRead;
        end else begin
          w_state = StIdle;
        end
      end
      default: w_state = StIdle;
    endcase
`ifdef OAM_DMA_RESTART_EN
    // The current cycle's bus strobe is driven from r_state, so a final WRITE still lands.
    if ((r_state != StIdle) && w_reg_store) begin
      w_state = StStart;
      w_src   = w_fold;
      w_idx   = 8'h00;
    end
`endif
  end

  always_comb begin
    bus_address = 16'h0000;
    bus_wdata   = 8'h00;
    bus_load    = 1'b0;
    bus_store   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!reset) begin
          bus_address = cpu_address;
          bus_wdata   = cpu_wdata;
          bus_store   = cpu_store;
          bus_load    = cpu_load && !cpu_store;
        end
      end
      StRead: begin
        bus_load    = 1'b1;
        bus_address = {r_src, r_idx};
      end
      StWrite: begin
        bus_store   = 1'b1;
        bus_address = OAM_BASE + {8'h00, r_idx};
        bus_wdata   = r_data;
      end
      default: ;
    endcase
  end

  assign dma_active = (r_state != StIdle);

  always_comb begin
    if (reset)           cpu_rdata = 8'h00;
    else if (r_rd_page)  cpu_rdata = r_page;
    else if (r_rd_owned) cpu_rdata = 8'hff;
    else                 cpu_rdata = bus_rdata;
  end

endmodule
